city_dispatch_ctrl: RTL and testbench
=====================================

Name: city_dispatch_ctrl

Overview:
- Scheduler in front of the 4-way city message demux (local_lib=00, fire=01, school=10, rib_shack=11).
- Accepts tagged 4-bit messages over a valid/ready interface and buffers them in two queues: emergency (dest=01, fire) and normal (all other destinations).
- Drives the demux enable/select/in for a fixed hold time per message.
- Emergency traffic has priority, with a starvation guard for normal traffic.

Parameters:
- DEPTH, 4, entries per queue (power of 2, ≥2).
- HOLD_CYCLES, 3, cycles dmx_enable stays high per dispatched message (≥1).
- MAX_BURST, 2, consecutive emergency dispatches allowed before a waiting normal message must be served (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_dest  input  2  destination select code.
- req_data  input  4  message payload.
- dmx_enable  output  1  demux enable.
- dmx_select  output  2  demux select.
- dmx_in  output  4  demux data.
- busy  output  1  high in HOLD state.
- emer_count  output  $clog2(DEPTH)+1  emergency queue occupancy.
- norm_count  output  $clog2(DEPTH)+1  normal queue occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - Both queues emptied; state=IDLE; burst_cnt=0; hold counter=0.
  - dmx_enable=0, dmx_select=0, dmx_in=0, busy=0; counts=0.
  - Outputs clear immediately, without waiting for a clock edge, including mid-HOLD.
- Accept:
  - req_ready = !full(target queue), where the target queue is selected combinationally by req_dest (01 → emergency, else normal).
  - Push on a rising edge with req_valid && req_ready. Entry stores {dest, data}.
  - req_ready uses occupancy before any same-cycle pop (no pass-through on full).
- FIFO order is preserved within each queue.
- State machine (registered outputs):
  - IDLE: dmx_enable=0.
    - If either queue is non-empty at an edge: pop the chosen entry, load dmx_select/dmx_in, set dmx_enable=1, load hold counter, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD: dmx_enable=1, busy=1 for exactly HOLD_CYCLES cycles, then return to IDLE with dmx_enable=0.
  - Every dispatch is therefore followed by at least one enable-low IDLE cycle.
  - Maximum throughput is one message per HOLD_CYCLES+1 cycles.
- Selection at pop:
  - Pick normal if normal is non-empty and (emergency is empty or burst_cnt==MAX_BURST).
  - Otherwise pick emergency if it is non-empty.
  - An emergency pop increments burst_cnt, saturating at MAX_BURST.
  - A normal pop clears burst_cnt to 0.
- dmx_select/dmx_in retain their last values while in IDLE; they change only at a pop.
- Push and pop on the same queue in the same edge are allowed: count unchanged, both operations take effect.
- Latency: a request accepted at edge k into an empty, idle controller gives dmx_enable=1 after edge k+1, falling after edge k+1+HOLD_CYCLES.
- New requests, including emergency ones, never preempt a message in HOLD.
- Counts are exact occupancies, range 0..DEPTH.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: queue dest=10 data=0xA; drop rst_n during HOLD.
  - Required: dmx_enable/dmx_select/dmx_in go to 0 immediately; counts 0; req_ready=1 after release; no residual dispatch.
- Single message:
  - Stimulus: accept dest=10 data=0xA at edge k.
  - Required: dmx_enable high for edges k+1..k+4 (3 cycles) with dmx_select=10, dmx_in=0xA; then low; busy tracks dmx_enable.
- Priority:
  - Stimulus: while holding, queue dest=00/0x1 then dest=01/0x5.
  - Required: next dispatch is select=01 in=0x5, then select=00 in=0x1.
- Starvation guard:
  - Stimulus: while holding, queue emergency 0x1,0x2,0x3,0x4 and normal dest=11/0x9.
  - Required: dispatch order 0x1, 0x2, 0x9(sel 11), 0x3, 0x4.
- Full/backpressure:
  - Stimulus: during HOLD, present 5 consecutive dest=10 requests.
  - Required: first 4 accepted (norm_count=4); 5th sees req_ready=0 and is not stored; emergency req_ready stays 1.
- Simultaneous push/pop:
  - Stimulus: normal queue holds 2 entries in IDLE; push a 3rd on the pop edge.
  - Required: norm_count stays 2; FIFO order is preserved across the next three dispatches.

Source files
------------

// File: rtl/city_dispatch_ctrl.sv
// City message dispatch controller: buffers tagged requests in an emergency
// queue and a normal queue, then drives the 4-way demux for a fixed hold time
// per message. Emergency traffic wins, but a waiting normal message is served
// after MAX_BURST back-to-back emergency dispatches.
module city_dispatch_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned MAX_BURST   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_dest_i,
    input  logic [3:0]               req_data_i,
    output logic                     dmx_enable_o,
    output logic [1:0]               dmx_select_o,
    output logic [3:0]               dmx_in_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   emer_count_o,
    output logic [$clog2(DEPTH):0]   norm_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      data_q, data_d;

    // Each entry is {dest, data}
    logic [5:0]      emer_mem_q [DEPTH];
    logic [5:0]      norm_mem_q [DEPTH];
    logic [AW-1:0]   emer_wr_q, emer_rd_q, norm_wr_q, norm_rd_q;
    logic [CW-1:0]   emer_cnt_q, emer_cnt_d, norm_cnt_q, norm_cnt_d;

    logic req_is_emer, emer_empty, norm_empty;
    logic push_emer, push_norm, do_pop, pick_norm, pop_emer, pop_norm;
    logic [5:0] pop_entry;

    // Accept/select decode; ready looks at occupancy before any same-edge pop
    always_comb begin
        req_is_emer = (req_dest_i == 2'b01);
        emer_empty  = (emer_cnt_q == '0);
        norm_empty  = (norm_cnt_q == '0);
        req_ready_o = req_is_emer ? (emer_cnt_q != CW'(DEPTH)) : (norm_cnt_q != CW'(DEPTH));
        push_emer   = req_valid_i && req_ready_o && req_is_emer;
        push_norm   = req_valid_i && req_ready_o && !req_is_emer;
        do_pop      = (state_q == StIdle) && (!emer_empty || !norm_empty);
        pick_norm   = !norm_empty && (emer_empty || (burst_q == BW'(MAX_BURST)));
        pop_norm    = do_pop && pick_norm;
        pop_emer    = do_pop && !pick_norm;
        pop_entry   = pop_norm ? norm_mem_q[norm_rd_q] : emer_mem_q[emer_rd_q];
        emer_cnt_d  = emer_cnt_q + CW'(push_emer) - CW'(pop_emer);
        norm_cnt_d  = norm_cnt_q + CW'(push_norm) - CW'(pop_norm);
    end

    // Queue storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push_emer) emer_mem_q[emer_wr_q] <= {req_dest_i, req_data_i};
        if (push_norm) norm_mem_q[norm_wr_q] <= {req_dest_i, req_data_i};
    end

    // Queue pointers and occupancies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emer_wr_q  <= '0;
            emer_rd_q  <= '0;
            norm_wr_q  <= '0;
            norm_rd_q  <= '0;
            emer_cnt_q <= '0;
            norm_cnt_q <= '0;
        end else begin
            if (push_emer) emer_wr_q <= emer_wr_q + AW'(1);
            if (pop_emer)  emer_rd_q <= emer_rd_q + AW'(1);
            if (push_norm) norm_wr_q <= norm_wr_q + AW'(1);
            if (pop_norm)  norm_rd_q <= norm_rd_q + AW'(1);
            emer_cnt_q <= emer_cnt_d;
            norm_cnt_q <= norm_cnt_d;
        end
    end

    // FSM and dispatch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            burst_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            burst_q <= burst_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    // Next state: pop from IDLE, count down the hold window in HOLD
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        burst_d = burst_q;
        sel_d   = sel_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (do_pop) begin
                    state_d = StHold;
                    hold_d  = HW'(HOLD_CYCLES - 1);
                    sel_d   = pop_entry[5:4];
                    data_d  = pop_entry[3:0];
                    if (pop_norm) begin
                        burst_d = '0;
                    end else if (burst_q != BW'(MAX_BURST)) begin
                        burst_d = burst_q + BW'(1);
                    end
                end
            end
            StHold: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        dmx_enable_o = (state_q == StHold);
        busy_o       = (state_q == StHold);
        dmx_select_o = sel_q;
        dmx_in_o     = data_q;
        emer_count_o = emer_cnt_q;
        norm_count_o = norm_cnt_q;
    end

endmodule

// File: tb/tb_city_dispatch_ctrl.sv
// Randomized and directed bench for city_dispatch_ctrl against a queue-based
// reference model.
module tb_city_dispatch_ctrl;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int MAXB  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [1:0] req_dest_i = '0;
    logic [3:0] req_data_i = '0;
    logic       dmx_enable_o;
    logic [1:0] dmx_select_o;
    logic [3:0] dmx_in_o;
    logic       busy_o;
    logic [2:0] emer_count_o;
    logic [2:0] norm_count_o;

    always #5 clk = ~clk;

    city_dispatch_ctrl #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD),
        .MAX_BURST  (MAXB)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_dest_i  (req_dest_i),
        .req_data_i  (req_data_i),
        .dmx_enable_o(dmx_enable_o),
        .dmx_select_o(dmx_select_o),
        .dmx_in_o    (dmx_in_o),
        .busy_o      (busy_o),
        .emer_count_o(emer_count_o),
        .norm_count_o(norm_count_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int eq[$];
    int nq[$];
    int burst;
    int hold_rem;
    int m_sel;
    int m_data;

    // Log of dispatches observed on the DUT ({sel, data})
    int   dlog[$];
    int   exp_log[$];
    logic prev_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        eq.delete();
        nq.delete();
        burst    = 0;
        hold_rem = 0;
        m_sel    = 0;
        m_data   = 0;
        prev_en  = 1'b0;
    endtask

    // One clock of stimulus plus model update and output comparison
    task automatic step(input bit v, input bit [1:0] d, input bit [3:0] dat);
        bit exp_rdy;
        bit acc;
        bit take_emer;
        int ent;
        req_valid_i = v;
        req_dest_i  = d;
        req_data_i  = dat;
        #1;
        exp_rdy = (d == 2'b01) ? (eq.size() < DEPTH) : (nq.size() < DEPTH);
        check_eq("req_ready", req_ready_o, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (hold_rem > 0) begin
            hold_rem--;
        end else if (eq.size() > 0 || nq.size() > 0) begin
            take_emer = !(nq.size() > 0 && (eq.size() == 0 || burst == MAXB));
            if (take_emer) begin
                ent = eq.pop_front();
                if (burst < MAXB) burst++;
            end else begin
                ent = nq.pop_front();
                burst = 0;
            end
            m_sel    = ent >> 4;
            m_data   = ent & 15;
            hold_rem = HOLD;
        end
        if (acc) begin
            if (d == 2'b01) eq.push_back({26'd0, d, dat});
            else            nq.push_back({26'd0, d, dat});
        end
        #1;
        check_eq("dmx_enable", dmx_enable_o, hold_rem > 0);
        check_eq("busy", busy_o, hold_rem > 0);
        check_eq("dmx_select", dmx_select_o, m_sel);
        check_eq("dmx_in", dmx_in_o, m_data);
        check_eq("emer_count", emer_count_o, eq.size());
        check_eq("norm_count", norm_count_o, nq.size());
        if (dmx_enable_o && !prev_en) dlog.push_back({26'd0, dmx_select_o, dmx_in_o});
        prev_en = dmx_enable_o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0);
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_ndisp"}, dlog.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < dlog.size(); i++) begin
            check_eq($sformatf("%s_disp%0d", tag, i), dlog[i], exp_log[i]);
        end
        dlog.delete();
        exp_log.delete();
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("rst_enable", dmx_enable_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_select", dmx_select_o, 0);
        check_eq("rst_in", dmx_in_o, 0);
        check_eq("rst_emer_count", emer_count_o, 0);
        check_eq("rst_norm_count", norm_count_o, 0);
        rst_n = 1'b1;

        // Single message
        step(1'b1, 2'b10, 4'hA);
        idle(6);
        exp_log.push_back('h2A);
        check_log("single");

        // Priority: emergency overtakes an earlier normal message
        step(1'b1, 2'b10, 4'hA);
        step(1'b1, 2'b00, 4'h1);
        step(1'b1, 2'b01, 4'h5);
        idle(12);
        exp_log.push_back('h2A);
        exp_log.push_back('h15);
        exp_log.push_back('h01);
        check_log("prio");

        // Starvation guard
        step(1'b1, 2'b10, 4'hA);
        step(1'b1, 2'b01, 4'h1);
        step(1'b1, 2'b01, 4'h2);
        step(1'b1, 2'b01, 4'h3);
        step(1'b1, 2'b01, 4'h4);
        step(1'b1, 2'b11, 4'h9);
        idle(28);
        exp_log.push_back('h2A);
        exp_log.push_back('h11);
        exp_log.push_back('h12);
        exp_log.push_back('h39);
        exp_log.push_back('h13);
        exp_log.push_back('h14);
        check_log("starve");

        // Full / backpressure on the normal queue
        step(1'b1, 2'b10, 4'hA);
        for (int i = 1; i <= 4; i++) step(1'b1, 2'b10, 4'(i));
        req_valid_i = 1'b0;
        req_dest_i  = 2'b01;
        #1;
        check_eq("norm_full_count", norm_count_o, 4);
        check_eq("emer_ready_norm_full", req_ready_o, 1);
        req_dest_i = 2'b10;
        #1;
        check_eq("norm_ready_full", req_ready_o, 0);
        step(1'b1, 2'b10, 4'h5);
        idle(24);
        exp_log.push_back('h2A);
        for (int i = 1; i <= 4; i++) exp_log.push_back('h20 + i);
        check_log("full");

        // Simultaneous push and pop on the normal queue
        step(1'b1, 2'b10, 4'hA);
        step(1'b1, 2'b00, 4'h1);
        step(1'b1, 2'b00, 4'h2);
        idle(2);
        check_eq("pp_pre_count", norm_count_o, 2);
        step(1'b1, 2'b00, 4'h3);
        check_eq("pp_post_count", norm_count_o, 2);
        idle(16);
        exp_log.push_back('h2A);
        exp_log.push_back('h01);
        exp_log.push_back('h02);
        exp_log.push_back('h03);
        check_log("pushpop");

        // Reset in the middle of HOLD
        step(1'b1, 2'b10, 4'hA);
        step(1'b1, 2'b00, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_enable", dmx_enable_o, 0);
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_select", dmx_select_o, 0);
        check_eq("midrst_in", dmx_in_o, 0);
        check_eq("midrst_norm_count", norm_count_o, 0);
        model_reset();
        dlog.delete();
        #3;
        rst_n = 1'b1;
        idle(6);
        check_log("midrst");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), 4'($urandom));
        end
        idle(50);
        dlog.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
